// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one external UART transmitter
// among N_REQ byte sources. One requester is granted at a time, its byte and
// baud select are latched toward the transmitter, send enable is held for the
// whole frame, and completion (done) or timeout (err) is reported back.
module uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 70000,
  parameter int GAP_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [3*N_REQ-1:0] i_req_baud,
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_done,
  output logic [N_REQ-1:0]   o_err,
  output logic               o_tx_send_en,
  output logic [7:0]         o_tx_data,
  output logic [2:0]         o_tx_baud,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic [2:0]         o_grant_id
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Index of the last requester; both the pointer and grant_id start here so
  // that requester 0 is first in line after reset.
  localparam logic [2:0] LAST_ID = 3'(N_REQ - 1);

  // Timeout counter is a fixed 17 bits; it fires on its TIMEOUT-1 count so the
  // err pulse lands exactly TIMEOUT cycles after send enable rises.
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT - 1);

  // Gap counter only needs to reach GAP_CYC-1.
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  // State and registered outputs
  logic [1:0]       r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_grant_id;
  logic [16:0]      r_to_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_tx_send_en;
  logic [7:0]       r_tx_data;
  logic [2:0]       r_tx_baud;
  logic             r_busy;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] r_err;

  // Arbitration wires
  logic [2:0]       w_cand [N_REQ];
  logic [N_REQ-1:0] w_cand_hit;
  logic [2:0]       w_win;
  logic             w_any;
  logic [7:0]       w_win_data;
  logic [2:0]       w_win_baud;
  logic [N_REQ-1:0] w_win_1h;
  logic [N_REQ-1:0] w_grant_1h;
  logic [7:0]       w_req_pad;

  // Pad the request vector to 8 bits so a 3-bit index always fits exactly.
  assign w_req_pad = 8'(i_req);

  // Candidate gi is the requester gi+1 positions after the pointer, wrapped
  // modulo N_REQ with a subtract (N_REQ need not be a power of two).
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [3:0] w_sum;
    assign w_sum          = {1'b0, r_ptr} + 4'(gi + 1);
    assign w_cand[gi]     = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : w_sum[2:0];
    assign w_cand_hit[gi] = w_req_pad[w_cand[gi]];
  end

  // Pick the nearest active candidate after the pointer (lowest gi wins).
  always_comb begin
    w_win = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_cand_hit[k]) begin
        w_win = w_cand[k];
      end
    end
  end

  assign w_any = |i_req;

  // Select the winner's byte and baud slices.
  always_comb begin
    w_win_data = 8'h00;
    w_win_baud = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == 3'(i)) begin
        w_win_data = i_req_data[8*i +: 8];
        w_win_baud = i_req_baud[3*i +: 3];
      end
    end
  end

  assign w_win_1h   = ONE_HOT0 << w_win;
  assign w_grant_1h = ONE_HOT0 << r_grant_id;

  // Main sequencer: IDLE grants, SEND holds the frame and watches for
  // completion or timeout, GAP enforces idle line time before the next grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= LAST_ID;
      r_grant_id   <= LAST_ID;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_tx_send_en <= 1'b0;
      r_busy       <= 1'b0;
      r_ack        <= '0;
      r_done       <= '0;
      r_err        <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_SEND;
            r_ptr        <= w_win;
            r_grant_id   <= w_win;
            r_ack        <= w_win_1h;
            r_to_cnt     <= '0;
            r_tx_send_en <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_SEND: begin
          r_to_cnt <= r_to_cnt + 17'd1;
          // Completion takes precedence over a coincident timeout.
          if (i_tx_done) begin
            r_done       <= w_grant_1h;
            r_state      <= S_GAP;
            r_gap_cnt    <= '0;
            r_tx_send_en <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            r_err        <= w_grant_1h;
            r_state      <= S_GAP;
            r_gap_cnt    <= '0;
            r_tx_send_en <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_tx_send_en <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Byte and baud toward the transmitter; loaded only on a grant so they stay
  // frozen for the whole frame and the gap after it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_data <= 8'h00;
      r_tx_baud <= 3'd0;
    end else if (r_state == S_IDLE && w_any) begin
      r_tx_data <= w_win_data;
      r_tx_baud <= w_win_baud;
    end
  end

  assign o_ack        = r_ack;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_tx_send_en = r_tx_send_en;
  assign o_tx_data    = r_tx_data;
  assign o_tx_baud    = r_tx_baud;
  assign o_busy       = r_busy;
  assign o_grant_id   = r_grant_id;

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` byte sources. Each requester presents a byte and its own baud selection. The arbiter grants one requester at a time, loads the transmitter's byte and baud inputs, and holds the transmitter's send enable for the whole frame. It then waits for frame completion, or times out, and reports back to the requester. It sits between application-side byte producers and the UART transmitter, with the transmitter instance outside this block.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 70000: clk cycles allowed in SEND before abort. Counter is 17 bits.
- `GAP_CYC`, 16: idle-line cycles enforced between frames, ≥1.

Ports:
- `clk` in 1: system clock (50 MHz nominal).
- `rst_n` in 1: asynchronous active-low reset.
- `req` in N_REQ: per-requester request level.
- `req_data` in 8*N_REQ: byte for requester i at bits [8i+7:8i].
- `req_baud` in 3*N_REQ: baud select for requester i at bits [3i+2:3i].
- `ack` out N_REQ: one-cycle pulse; byte of requester i captured.
- `done` out N_REQ: one-cycle pulse; frame of requester i finished OK.
- `err` out N_REQ: one-cycle pulse; frame of requester i timed out.
- `tx_send_en` out 1: transmitter send enable, level-held for the whole frame.
- `tx_data` out 8: byte to transmitter.
- `tx_baud` out 3: baud select to transmitter.
- `tx_done` in 1: transmitter frame-complete pulse.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out 3: index of current or last grant.

## Operation
States: IDLE, SEND, GAP.

- **IDLE**
  - If `req` != 0, select the winner. Search from `ptr+1` upward and wrap modulo N_REQ; the first set bit wins.
  - Register `tx_data` and `tx_baud` from the winner's slices, set `grant_id` and `ptr` to the winner, pulse `ack[winner]`, clear the timeout counter, go to SEND.
  - If `req` == 0, stay in IDLE.
- **SEND**
  - `tx_send_en` = 1. `tx_data`, `tx_baud` and `grant_id` stay frozen; `req` and `req_data` changes are ignored.
  - The timeout counter increments every cycle.
  - `tx_done` = 1: pulse `done[grant_id]`, go to GAP.
  - Otherwise, counter == TIMEOUT-1: pulse `err[grant_id]`, go to GAP.
  - `tx_done` and timeout in the same cycle: `tx_done` wins, `done` only.
- **GAP**
  - `tx_send_en` = 0. Count GAP_CYC cycles, then go to IDLE.
  - `tx_done` arriving in GAP or IDLE is ignored.

Requester rules:
- A requester holds `req[i]` until it sees `ack[i]`. Dropping `req[i]` earlier withdraws the request with no error.
- `req[i]` still high after `ack[i]` is a new request, using the data present at its next grant.

Arbitration fairness:
- `ptr` resets to N_REQ-1, so requester 0 has first priority after reset.
- With all requesters active, grants cycle 0,1,...,N_REQ-1,0.

Arithmetic:
- The search index wraps with modulo N_REQ; it is not a power-of-two mask, so N_REQ=3,5,6,7 must work.
- Counters saturate at no point; each is cleared on state entry.

Reset:
- Asserting `rst_n` low, at any time including mid-SEND, forces IDLE immediately.
- Reset values: `tx_send_en`=0, `tx_data`=0, `tx_baud`=0, `ack`/`done`/`err`=0, `busy`=0, `grant_id`=N_REQ-1, `ptr`=N_REQ-1.
- No done/err pulse is issued for a frame aborted by reset.

## Timing
All outputs are registered.

Launch:
- `req` sampled high in IDLE at edge t.
- At t+1: state SEND, `tx_send_en`=1, `tx_data`/`tx_baud` valid, `ack` high for that one cycle, `busy`=1.

Completion:
- `tx_done` sampled high at edge u in SEND.
- At u+1: `tx_send_en`=0 and `done` high for one cycle.
- GAP occupies u+1..u+GAP_CYC; IDLE at u+GAP_CYC+1, and `busy` falls there.
- The earliest next `ack` is at u+GAP_CYC+2.

Timeout:
- The `err` pulse comes exactly TIMEOUT cycles after `tx_send_en` rises.

Back-to-back bound:
- Consecutive frames are at least frame length + GAP_CYC + 2 cycles apart.

## Test plan
- **Reset values:** release `rst_n` with `req`=0 → all outputs at reset values, `busy`=0, no pulses for 100 cycles.
- **Single request:** `req`=4'b0100, data 0xA5, baud 3'd4; tx model asserts `tx_done` 5000 cycles after send_en →
  - `ack[2]` one cycle after req.
  - `tx_data`=0xA5, `tx_baud`=4, `tx_send_en` high exactly 5001 cycles.
  - `done[2]` pulse; `busy` low GAP_CYC+1 cycles later.
- **Round-robin:** `req`=4'b1111 held constantly with distinct bytes 0x10..0x13 → grant order 0,1,2,3,0,1; `tx_data` sequence 0x10,0x11,0x12,0x13,0x10,0x11.
- **Timeout:** `req[1]`=1, tx model never pulses `tx_done` →
  - `err[1]` exactly 70000 cycles after `tx_send_en` rises, no `done`.
  - Arbiter returns to IDLE and serves `req[3]` next.
- **Simultaneous tx_done and timeout:** force `tx_done` on the TIMEOUT-1 cycle → `done` pulses, `err` stays 0.
- **Reset mid-SEND:** pull `rst_n` low 300 cycles into a frame → `tx_send_en`=0 and `busy`=0 asynchronously. After release, `req`=4'b0011 is granted to requester 0 first, with no stale done/err pulse.
